seven_seg_scanner: RTL
======================

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of multiplexed digits (range 2..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 50000, clock cycles each digit is lit per slot (at least 1).
REQ-003 SHALL have parameter GUARD, default 2, all-anodes-off cycles before each digit slot (at least 1).
REQ-004 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port load, input, 1, one-cycle strobe capturing valueIn and dpIn.
REQ-007 SHALL have port valueIn, input, 4*DIGITS, hex nibbles; nibble k (bits 4k+3:4k) is digit k, digit 0 rightmost.
REQ-008 SHALL have port dpIn, input, DIGITS, decimal-point request per digit, active-high.
REQ-009 SHALL have port hexOut, output, 4, nibble for the downstream 7-segment decoder.
REQ-010 SHALL have port anodeOut, output, DIGITS, digit enables, active-low.
REQ-011 SHALL have port dpOut, output, 1, decimal-point segment, active-low.
REQ-012 SHALL have port frameTick, output, 1, one-cycle pulse at each frame start.

Function
REQ-013 SHALL register every output; no combinational path from any input to any output.
REQ-014 SHALL implement two states: BLANK (GUARD cycles) and SHOW (REFRESH_DIV cycles), plus digit index idx (0..DIGITS-1) and a cycle counter.
REQ-015 In BLANK, anodeOut SHALL be all ones, dpOut 1, and hexOut SHALL already equal the nibble of digit idx.
REQ-016 In SHOW, anodeOut bit idx SHALL be 0 and all other bits 1, hexOut the nibble of digit idx, dpOut = NOT dp of digit idx.
REQ-017 After the last SHOW cycle, idx SHALL increment, wrapping DIGITS-1 to 0, and the state SHALL return to BLANK.
REQ-018 Each digit slot SHALL last exactly GUARD+REFRESH_DIV cycles; a frame SHALL last DIGITS*(GUARD+REFRESH_DIV) cycles.
REQ-019 On load, valueIn/dpIn SHALL be captured into a shadow register on that edge, independent of scan state.
REQ-020 The display register SHALL copy the shadow register only on the edge where idx wraps to 0 (frame start), so a frame never mixes old and new digits.
REQ-021 frameTick SHALL be 1 for exactly the first BLANK cycle of digit 0 in every frame.
REQ-022 Multiple loads within one frame: the last one wins.
REQ-023 Load coincident with a frame-start edge: the transfer uses the previous shadow; the new value displays from the following frame.
REQ-024 At most one anodeOut bit SHALL be 0 in any cycle.

Reset
REQ-025 rst high SHALL immediately, without a clock edge, force: state BLANK, idx 0, counter 0, shadow and display 0, anodeOut all ones, hexOut 0, dpOut 1, frameTick 0.
REQ-026 rst asserted mid-slot or mid-load SHALL discard the captured value and partial count.
REQ-027 After rst deasserts, the first rising edge SHALL begin a frame at digit 0, with frameTick high on that cycle.

Configuration
REQ-028 Macro LEADING_ZERO_BLANK_EN: when defined, any digit k>0 whose nibble and every higher nibble are 0 and whose dp bit is 0 SHALL keep its anode high during SHOW; slot timing is unchanged and digit 0 is never blanked.
REQ-029 Without LEADING_ZERO_BLANK_EN, every digit SHALL be lit in its slot regardless of value.

Verification (DIGITS=4, REFRESH_DIV=4, GUARD=1)
REQ-030 Reset then no load -> anodeOut walks 1110,1101,1011,0111 for 4 cycles each, separated by 1-cycle 1111 gaps, hexOut 0, frameTick every 20 cycles.
REQ-031 Load valueIn=16'h12AF, dpIn=4'b0100 mid-frame -> old value finishes the frame; next frame shows hexOut F,A,2,1 on digits 0..3, with dpOut 0 only while digit 2 is lit.
REQ-032 Load 16'h1111 then 16'h2222 in the same frame -> next frame shows all 2s; load on the frame-start edge -> value appears one frame later.
REQ-033 Assert rst for 1 ns between edges mid-SHOW of digit 2 -> outputs reach reset values before the next edge; scan restarts at digit 0.
REQ-034 With LEADING_ZERO_BLANK_EN, load 16'h0050 -> digits 3 and 2 stay anode-high, digits 1 and 0 lit; without the macro all four are lit.
REQ-035 Every cycle of every test -> assert at most one anodeOut bit is 0 and the frame period equals 20 cycles.

Source files
------------

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed hex display driver with guard gaps and frame-synchronous updates.
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module seven_seg_scanner #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   valueIn,
  input  logic [DIGITS-1:0]     dpIn,
  output logic [3:0]            hexOut,
  output logic [DIGITS-1:0]     anodeOut,
  output logic                  dpOut,
  output logic                  frameTick
);
  localparam int CMAX = GUARD > REFRESH_DIV ? GUARD : REFRESH_DIV;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = $clog2(DIGITS);
  typedef enum logic {BLANK, SHOW} state_t;
  state_t              r_state, w_state;
  logic                r_run, w_fs, w_last;
  logic [IW-1:0]       r_idx, w_idx;
  logic [CW-1:0]       r_cnt, w_cnt;
  logic [4*DIGITS-1:0] r_shv, r_dv, w_dv;
  logic [DIGITS-1:0]   r_shd, r_dd, w_dd, w_blank;
  // r_run is clear only in the cycle after reset, so the first edge always opens a fresh frame
  always_comb begin
    w_state = r_state;
    w_idx   = r_idx;
    w_cnt   = r_cnt + 1'b1;
    w_fs    = 1'b0;
    w_last  = r_state == BLANK ? r_cnt == CW'(GUARD - 1) : r_cnt == CW'(REFRESH_DIV - 1);
    if (!r_run) begin
      w_state = BLANK;
      w_idx   = '0;
      w_cnt   = '0;
      w_fs    = 1'b1;
    end else if (w_last) begin
      w_cnt   = '0;
      w_state = r_state == BLANK ? SHOW : BLANK;
      if (r_state == SHOW) begin
        w_idx = r_idx == IW'(DIGITS - 1) ? '0 : r_idx + 1'b1;
        w_fs  = r_idx == IW'(DIGITS - 1);
      end
    end
    w_dv = w_fs ? r_shv : r_dv;
    w_dd = w_fs ? r_shd : r_dd;
  end
`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    logic w_z;
    w_blank = '0;
    w_z     = 1'b1;
    for (int k = DIGITS - 1; k > 0; k--) begin
      w_z        = w_z && (w_dv[4*k +: 4] == 4'h0);
      w_blank[k] = w_z && !w_dd[k];
    end
  end
`else
  assign w_blank = '0;
`endif
  // outputs are registered from next-state values so they stay aligned with the scan state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run     <= 1'b0;
      r_state   <= BLANK;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_shv     <= '0;
      r_shd     <= '0;
      r_dv      <= '0;
      r_dd      <= '0;
      hexOut    <= 4'h0;
      anodeOut  <= '1;
      dpOut     <= 1'b1;
      frameTick <= 1'b0;
    end else begin
      r_run     <= 1'b1;
      r_state   <= w_state;
      r_idx     <= w_idx;
      r_cnt     <= w_cnt;
      if (load) begin
        r_shv <= valueIn;
        r_shd <= dpIn;
      end
      r_dv      <= w_dv;
      r_dd      <= w_dd;
      hexOut    <= w_dv[4*w_idx +: 4];
      anodeOut  <= (w_state == SHOW && !w_blank[w_idx]) ? ~(DIGITS'(1) << w_idx) : '1;
      dpOut     <= !(w_state == SHOW && w_dd[w_idx]);
      frameTick <= w_fs;
    end
  end
endmodule
